// File: rtl/cpu_dbg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared definitions for the CPU debug controller slice:
//   - cmd_op_e    : host debug command encodings carried on cmd_op
//   - dbg_state_e : controller state encoding
//   - default sizes for the GPR dump length and the step counter width
// ---------------------------------------------------------------------------
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_RUN   = 3'd1,
    OP_HALT  = 3'd2,
    OP_STEP  = 3'd3,
    OP_DUMP  = 3'd4,
    OP_SETBP = 3'd5,
    OP_CLRBP = 3'd6,
    OP_RSVD  = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_HALT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STEP     = 3'd2,
    ST_DUMP_SEL = 3'd3,
    ST_DUMP_OUT = 3'd4
  } dbg_state_e;

  localparam int DUMP_REGS_DEF  = 32;
  localparam int STEP_CNT_W_DEF = 16;

endpackage

// File: rtl/cpu_dbg_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_dbg_ctrl_if
// Host-facing channels of the debug controller.
//   Command channel (host -> ctrl): cmd_valid, cmd_ready, cmd_op[2:0], cmd_arg[31:0]
//   Dump channel    (ctrl -> host): dump_valid, dump_ready, dump_idx[4:0], dump_data[31:0]
// Modports:
//   master : host side (issues commands, consumes dump beats)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface cpu_dbg_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, dump_ready,
    input  cmd_ready, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, dump_ready,
    output cmd_ready, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/cpu_dbg_ctrl_bp_match.sv
// ---------------------------------------------------------------------------
// dbg_bp_match
// Single-address PC breakpoint for the debug controller. Only instantiated
// when CPU_DBG_BREAKPOINT_EN is defined.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (disarms)
//   set_bp      : arm with bp_addr_in (accepted SETBP)
//   clr_bp      : disarm (accepted CLRBP)
//   bp_addr_in  : breakpoint address to capture
//   pc          : core current PC
//   en_q        : registered core enable (core is trying to execute)
//   resume      : accepted RUN/STEP leaving HALT
//   hit         : combinational match; caller forces the core enable low
// ---------------------------------------------------------------------------
module dbg_bp_match (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_bp,
  input  logic        clr_bp,
  input  logic [31:0] bp_addr_in,
  input  logic [31:0] pc,
  input  logic        en_q,
  input  logic        resume,
  output logic        hit
);

  logic        armed_q, armed_d;
  logic [31:0] bp_addr_q, bp_addr_d;
  logic        skip_q, skip_d;

  // Arm/disarm the breakpoint and track the resume-skip window. The skip
  // flag lets the core execute the instruction sitting at the breakpoint
  // address on the first enabled cycle after a resume.
  always_comb begin
    armed_d   = armed_q;
    bp_addr_d = bp_addr_q;
    skip_d    = skip_q;
    if (set_bp) begin
      armed_d   = 1'b1;
      bp_addr_d = bp_addr_in;
    end
    if (clr_bp) begin
      armed_d = 1'b0;
    end
    if (resume) begin
      skip_d = 1'b1;
    end else if (en_q) begin
      skip_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b0;
      bp_addr_q <= '0;
      skip_q    <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      bp_addr_q <= bp_addr_d;
      skip_q    <= skip_d;
    end
  end

  assign hit = armed_q && en_q && !skip_q && (pc == bp_addr_q);

endmodule

// File: rtl/cpu_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_dbg_ctrl
// Run/halt/step/dump controller for the single-cycle CPU core. Gates core
// execution through cpu_en and walks the core's debug register-read port to
// stream every GPR out over the dump channel.
//
// Parameters:
//   DUMP_REGS   : number of GPRs streamed by DUMP (indices 0..DUMP_REGS-1, max 32)
//   STEP_CNT_W  : width of the step counter, STEP count = cmd_arg[STEP_CNT_W-1:0]
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : cpu_dbg_ctrl_if.slave (command channel in, dump channel out)
//   cpu_en      : core enable (PC/RF update only when 1)
//   pc          : core current PC
//   reg_sel     : core debug register select
//   reg_data    : core debug register data (combinational from reg_sel)
//   halted      : 1 while in HALT
//   bp_hit      : sticky, last stop caused by the breakpoint
//   retired     : count of cycles with cpu_en=1 (wraps, cleared only by rst)
// Configuration:
//   CPU_DBG_BREAKPOINT_EN : when defined, SETBP/CLRBP control a PC breakpoint
//   (dbg_bp_match). When undefined, SETBP/CLRBP are accepted and ignored,
//   bp_hit is 0 and cpu_en comes straight from its register.
// ---------------------------------------------------------------------------
module cpu_dbg_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DUMP_REGS  = DUMP_REGS_DEF,
  parameter int STEP_CNT_W = STEP_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_dbg_ctrl_if.slave        bus,
  output logic                 cpu_en,
  input  logic [31:0]          pc,
  output logic [4:0]           reg_sel,
  input  logic [31:0]          reg_data,
  output logic                 halted,
  output logic                 bp_hit,
  output logic [31:0]          retired
);

  localparam logic [4:0] LAST_IDX = 5'(DUMP_REGS - 1);

  dbg_state_e            state_q, state_d;
  logic                  cpu_en_q, cpu_en_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            dump_idx_q, dump_idx_d;
  logic [31:0]           dump_data_q, dump_data_d;
  logic [31:0]           retired_q, retired_d;

  logic                  accept;
  logic                  resume;
  logic                  bp_stop;
  logic [STEP_CNT_W-1:0] step_arg;

  assign bus.cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign step_arg      = bus.cmd_arg[STEP_CNT_W-1:0];

  // Only RUN/STEP taken from HALT actually start execution; those are the
  // points that clear bp_hit and open the resume-skip window.
  assign resume = accept && (state_q == ST_HALT) &&
                  ((bus.cmd_op == OP_RUN) || (bus.cmd_op == OP_STEP));

`ifdef CPU_DBG_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;

  dbg_bp_match u_bp_match (
    .clk        (clk),
    .rst        (rst),
    .set_bp     (accept && (bus.cmd_op == OP_SETBP)),
    .clr_bp     (accept && (bus.cmd_op == OP_CLRBP)),
    .bp_addr_in (bus.cmd_arg),
    .pc         (pc),
    .en_q       (cpu_en_q),
    .resume     (resume),
    .hit        (bp_stop)
  );

  // Sticky breakpoint flag: a hit wins over anything else in that cycle.
  always_comb begin
    bp_hit_d = bp_hit_q;
    if (resume) begin
      bp_hit_d = 1'b0;
    end
    if (bp_stop) begin
      bp_hit_d = 1'b1;
    end
  end

  // Breakpoint flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp_inputs;

  assign bp_stop          = 1'b0;
  assign bp_hit           = 1'b0;
  assign unused_bp_inputs = ^{pc, bus.cmd_arg};
`endif

  // Next-state logic. cpu_en is derived from the next state so that it is
  // registered and follows an accepted command by exactly one cycle.
  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    idx_d       = idx_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;

    case (state_q)
      ST_HALT: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
            end
            OP_STEP: begin
              state_d    = ST_STEP;
              step_cnt_d = (step_arg == '0) ? STEP_CNT_W'(1) : step_arg;
            end
            OP_DUMP: begin
              state_d = ST_DUMP_SEL;
              idx_d   = '0;
            end
            default: begin
              state_d = ST_HALT;
            end
          endcase
        end
      end

      ST_RUN: begin
        if (bp_stop || (accept && (bus.cmd_op == OP_HALT))) begin
          state_d = ST_HALT;
        end
      end

      ST_STEP: begin
        if (bp_stop || (step_cnt_q <= STEP_CNT_W'(1))) begin
          state_d = ST_HALT;
        end else begin
          step_cnt_d = step_cnt_q - STEP_CNT_W'(1);
        end
      end

      ST_DUMP_SEL: begin
        dump_data_d = reg_data;
        dump_idx_d  = idx_q;
        state_d     = ST_DUMP_OUT;
      end

      ST_DUMP_OUT: begin
        if (bus.dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_HALT;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_DUMP_SEL;
          end
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase

    cpu_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  // A breakpoint match suppresses the enable in the matching cycle itself,
  // so the instruction at the breakpoint address never executes.
  assign cpu_en    = cpu_en_q && !bp_stop;
  assign retired_d = retired_q + (cpu_en ? 32'd1 : 32'd0);

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HALT;
      cpu_en_q    <= 1'b0;
      step_cnt_q  <= '0;
      idx_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      step_cnt_q  <= step_cnt_d;
      idx_q       <= idx_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
      retired_q   <= retired_d;
    end
  end

  assign reg_sel        = (state_q == ST_DUMP_SEL) ? idx_q : 5'd0;
  assign bus.dump_valid = (state_q == ST_DUMP_OUT);
  assign bus.dump_idx   = dump_idx_q;
  assign bus.dump_data  = dump_data_q;
  assign halted         = (state_q == ST_HALT);
  assign retired        = retired_q;

endmodule
